// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter sharing one AWxDW RAM between two requesters.
//
// Grants are combinational from the request valids and a 1-bit priority
// pointer. The winner drives either the RAM write port or the RAM read port.
// Each read grant pushes a {valid, id} tag into a pipe that is RD_LAT deep.
// The tag pipe output routes i_ram_rdata back to the requester that issued
// the read.
//
// Optional feature: define RAM_ARB_COUNT_EN to add per-requester saturating
// 16-bit grant counters (o_gnt0_cnt / o_gnt1_cnt).
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_reqN_valid/we/addr/wdata   request N (N = 0, 1)
//   o_reqN_ready                 grant; a transfer occurs on valid & ready
//   o_rspN_valid/rdata           read response for requester N
//   o_ram_we/waddr/wdata         RAM write port
//   o_ram_re/raddr, i_ram_rdata  RAM read port
//   o_gntN_cnt                   transfer counters (RAM_ARB_COUNT_EN only)

module ram_arb #(
    parameter int AW     = 9,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic          i_req0_we,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_wdata,
    input  logic          i_req1_valid,
    input  logic          i_req1_we,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_wdata,
    output logic          o_req0_ready,
    output logic          o_req1_ready,
    output logic          o_rsp0_valid,
    output logic [DW-1:0] o_rsp0_rdata,
    output logic          o_rsp1_valid,
    output logic [DW-1:0] o_rsp1_rdata,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_waddr,
    output logic [DW-1:0] o_ram_wdata,
    output logic          o_ram_re,
    output logic [AW-1:0] o_ram_raddr,
    input  logic [DW-1:0] i_ram_rdata
`ifdef RAM_ARB_COUNT_EN
    ,
    output logic [15:0]   o_gnt0_cnt,
    output logic [15:0]   o_gnt1_cnt
`endif
);

    logic          prio;
    logic          gnt0;
    logic          gnt1;
    logic          xfer;
    logic          winner;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_id;
    logic              rsp_v;

    // Grant a lone requester outright; on contention the pointer decides.
    // Reset suppresses every grant so nothing reaches the RAM.
    always_comb begin
        gnt0 = ~i_rst & i_req0_valid & (~i_req1_valid | ~prio);
        gnt1 = ~i_rst & i_req1_valid & (~i_req0_valid |  prio);
    end

    assign xfer   = gnt0 | gnt1;
    assign winner = gnt1;

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    always_comb begin
        sel_we    = winner ? i_req1_we    : i_req0_we;
        sel_addr  = winner ? i_req1_addr  : i_req0_addr;
        sel_wdata = winner ? i_req1_wdata : i_req0_wdata;
    end

    // The unused RAM port is held at zero rather than mirroring the request.
    always_comb begin
        o_ram_we    = xfer & sel_we;
        o_ram_waddr = (xfer &  sel_we) ? sel_addr  : '0;
        o_ram_wdata = (xfer &  sel_we) ? sel_wdata : '0;
        o_ram_re    = xfer & ~sel_we;
        o_ram_raddr = (xfer & ~sel_we) ? sel_addr  : '0;
    end

    // After a transfer, the loser holds priority for the next contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= ~winner;
        end
    end

    // Read tag pipe. Stage 0 is loaded in the grant cycle. The last stage
    // therefore lines up with i_ram_rdata RD_LAT cycles later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= o_ram_re;
            tag_id[0] <= winner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // Gating with i_rst also covers a tag that is just emerging while reset is high.
    assign rsp_v = tag_v[RD_LAT-1] & ~i_rst;

    always_comb begin
        o_rsp0_valid = rsp_v & ~tag_id[RD_LAT-1];
        o_rsp1_valid = rsp_v &  tag_id[RD_LAT-1];
        o_rsp0_rdata = o_rsp0_valid ? i_ram_rdata : '0;
        o_rsp1_rdata = o_rsp1_valid ? i_ram_rdata : '0;
    end

`ifdef RAM_ARB_COUNT_EN
    logic [15:0] gnt0_cnt;
    logic [15:0] gnt1_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (gnt0 && (gnt0_cnt != 16'hFFFF)) begin
                gnt0_cnt <= gnt0_cnt + 16'd1;
            end
            if (gnt1 && (gnt1_cnt != 16'hFFFF)) begin
                gnt1_cnt <= gnt1_cnt + 16'd1;
            end
        end
    end

    assign o_gnt0_cnt = gnt0_cnt;
    assign o_gnt1_cnt = gnt1_cnt;
`endif

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb. Two instances are driven with the same stimulus. One
// instance uses RD_LAT=1 and the other uses RD_LAT=3. Each instance has its
// own RAM model. A reference model, written from the arbitration rules, is
// compared against both instances on every negative clock edge.
module tb_ram_arb;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          v0, we0, v1, we1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    logic          rdy0_1, rdy1_1, rv0_1, rv1_1, rwe_1, rre_1;
    logic [AW-1:0] rwa_1, rra_1;
    logic [DW-1:0] rd0_1, rd1_1, rwd_1, rram_1;
    logic          rdy0_3, rdy1_3, rv0_3, rv1_3, rwe_3, rre_3;
    logic [AW-1:0] rwa_3, rra_3;
    logic [DW-1:0] rd0_3, rd1_3, rwd_3, rram_3;
`ifdef RAM_ARB_COUNT_EN
    logic [15:0]   c0_1, c1_1, c0_3, c1_3;
`endif

    ram_arb #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_we(we0), .i_req0_addr(a0), .i_req0_wdata(d0),
        .i_req1_valid(v1), .i_req1_we(we1), .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_req0_ready(rdy0_1), .o_req1_ready(rdy1_1),
        .o_rsp0_valid(rv0_1), .o_rsp0_rdata(rd0_1),
        .o_rsp1_valid(rv1_1), .o_rsp1_rdata(rd1_1),
        .o_ram_we(rwe_1), .o_ram_waddr(rwa_1), .o_ram_wdata(rwd_1),
        .o_ram_re(rre_1), .o_ram_raddr(rra_1), .i_ram_rdata(rram_1)
`ifdef RAM_ARB_COUNT_EN
        , .o_gnt0_cnt(c0_1), .o_gnt1_cnt(c1_1)
`endif
    );

    ram_arb #(.AW(AW), .DW(DW), .RD_LAT(3)) u_lat3 (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .i_req0_we(we0), .i_req0_addr(a0), .i_req0_wdata(d0),
        .i_req1_valid(v1), .i_req1_we(we1), .i_req1_addr(a1), .i_req1_wdata(d1),
        .o_req0_ready(rdy0_3), .o_req1_ready(rdy1_3),
        .o_rsp0_valid(rv0_3), .o_rsp0_rdata(rd0_3),
        .o_rsp1_valid(rv1_3), .o_rsp1_rdata(rd1_3),
        .o_ram_we(rwe_3), .o_ram_waddr(rwa_3), .o_ram_wdata(rwd_3),
        .o_ram_re(rre_3), .o_ram_raddr(rra_3), .i_ram_rdata(rram_3)
`ifdef RAM_ARB_COUNT_EN
        , .o_gnt0_cnt(c0_3), .o_gnt1_cnt(c1_3)
`endif
    );

    // RAM models with read latency 1 and 3.
    logic [DW-1:0] mem1 [512] = '{default: '0};
    logic [DW-1:0] mem3 [512] = '{default: '0};
    logic [DW-1:0] p1 = '0;
    logic [DW-1:0] p3 [3] = '{default: '0};

    always @(posedge clk) begin
        if (rwe_1) mem1[rwa_1] <= rwd_1;
        p1 <= rre_1 ? mem1[rra_1] : '0;
    end
    assign rram_1 = p1;

    always @(posedge clk) begin
        if (rwe_3) mem3[rwa_3] <= rwd_3;
        p3[0] <= rre_3 ? mem3[rra_3] : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rram_3 = p3[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: state kept as plain arithmetic values and queues.
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } rsp_t;

    bit            m_prio = 1'b0;
    logic [DW-1:0] m_mem [512] = '{default: '0};
    rsp_t          q1[$];
    rsp_t          q3[$];
    int            cyc = 0;
    int            m_cnt0 = 0;
    int            m_cnt1 = 0;

    bit            m_any, m_win, m_we;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    bit            e0v1, e1v1, e0v3, e1v3;
    logic [DW-1:0] e0d1, e1d1, e0d3, e1d3;

    always @(negedge clk) begin
        m_any = !rst && (v0 || v1);
        m_win = (v0 && v1) ? m_prio : v1;
        m_we  = m_win ? we1 : we0;
        m_a   = m_win ? a1 : a0;
        m_d   = m_win ? d1 : d0;

        chk("rdy0_l1", rdy0_1, m_any && !m_win);
        chk("rdy1_l1", rdy1_1, m_any &&  m_win);
        chk("rdy0_l3", rdy0_3, m_any && !m_win);
        chk("rdy1_l3", rdy1_3, m_any &&  m_win);
        chk("ram_we_l1", rwe_1, m_any && m_we);
        chk("ram_re_l1", rre_1, m_any && !m_we);
        chk("ram_waddr_l1", rwa_1, (m_any && m_we) ? m_a : '0);
        chk("ram_wdata_l1", rwd_1, (m_any && m_we) ? m_d : '0);
        chk("ram_raddr_l1", rra_1, (m_any && !m_we) ? m_a : '0);
        chk("ram_we_l3", rwe_3, m_any && m_we);
        chk("ram_re_l3", rre_3, m_any && !m_we);
        chk("ram_waddr_l3", rwa_3, (m_any && m_we) ? m_a : '0);
        chk("ram_wdata_l3", rwd_3, (m_any && m_we) ? m_d : '0);
        chk("ram_raddr_l3", rra_3, (m_any && !m_we) ? m_a : '0);

        e0v1 = 0; e1v1 = 0; e0d1 = '0; e1d1 = '0;
        e0v3 = 0; e1v3 = 0; e0d3 = '0; e1d3 = '0;
        if (!rst) begin
            foreach (q1[i]) if (q1[i].due == cyc) begin
                if (q1[i].id) begin e1v1 = 1; e1d1 = q1[i].data; end
                else          begin e0v1 = 1; e0d1 = q1[i].data; end
            end
            foreach (q3[i]) if (q3[i].due == cyc) begin
                if (q3[i].id) begin e1v3 = 1; e1d3 = q3[i].data; end
                else          begin e0v3 = 1; e0d3 = q3[i].data; end
            end
        end
        chk("rsp0_valid_l1", rv0_1, e0v1);
        chk("rsp0_rdata_l1", rd0_1, e0d1);
        chk("rsp1_valid_l1", rv1_1, e1v1);
        chk("rsp1_rdata_l1", rd1_1, e1d1);
        chk("rsp0_valid_l3", rv0_3, e0v3);
        chk("rsp0_rdata_l3", rd0_3, e0d3);
        chk("rsp1_valid_l3", rv1_3, e1v3);
        chk("rsp1_rdata_l3", rd1_3, e1d3);
`ifdef RAM_ARB_COUNT_EN
        chk("gnt0_cnt_l1", c0_1, m_cnt0);
        chk("gnt1_cnt_l1", c1_1, m_cnt1);
        chk("gnt0_cnt_l3", c0_3, m_cnt0);
        chk("gnt1_cnt_l3", c1_3, m_cnt1);
`endif

        while (q1.size() > 0 && q1[0].due <= cyc) void'(q1.pop_front());
        while (q3.size() > 0 && q3[0].due <= cyc) void'(q3.pop_front());

        if (rst) begin
            m_prio = 0;
            q1.delete();
            q3.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (m_any) begin
            m_prio = !m_win;
            if (m_win) m_cnt1 = (m_cnt1 == 16'hFFFF) ? m_cnt1 : m_cnt1 + 1;
            else       m_cnt0 = (m_cnt0 == 16'hFFFF) ? m_cnt0 : m_cnt0 + 1;
            if (m_we) begin
                m_mem[m_a] = m_d;
            end else begin
                q1.push_back('{due: cyc + 1, id: m_win, data: m_mem[m_a]});
                q3.push_back('{due: cyc + 3, id: m_win, data: m_mem[m_a]});
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v0 = 0; v1 = 0;
        repeat (n) step();
    endtask

    initial begin
        // Reset held with both requesters valid.
        rst = 1;
        v0 = 1; we0 = 1; a0 = 9'h001; d0 = 8'h11;
        v1 = 1; we1 = 1; a1 = 9'h002; d1 = 8'h22;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdy0", rdy0_1, 0);
            chk("rst_rdy1", rdy1_3, 0);
            chk("rst_ram_we", rwe_1, 0);
            chk("rst_ram_waddr", rwa_3, 0);
            chk("rst_rsp0", rv0_1, 0);
            step();
        end
        rst = 0;
        @(negedge clk);
        chk("first_gnt_req0", rdy0_1, 1);
        chk("first_gnt_req1", rdy1_1, 0);
        step();
        v0 = 0;
        step();
        idle(1);

        // req0 writes, then reads back the same address.
        v0 = 1; we0 = 1; a0 = 9'h1A5; d0 = 8'hC3;
        step();
        we0 = 0;
        @(negedge clk);
        chk("wr_rd_re", rre_1, 1);
        step();
        v0 = 0;
        @(negedge clk);
        chk("wr_rd_rsp0_l1", rv0_1, 1);
        chk("wr_rd_data_l1", rd0_1, 8'hC3);
        chk("wr_rd_rsp1_l1", rv1_1, 0);
        step();
        step();
        @(negedge clk);
        chk("wr_rd_rsp0_l3", rv0_3, 1);
        chk("wr_rd_data_l3", rd0_3, 8'hC3);
        step();
        idle(2);

        // Preload the addresses used by the contention reads.
        v0 = 1; we0 = 1; a0 = 9'h010; d0 = 8'h5A;
        step();
        v0 = 0;
        v1 = 1; we1 = 1; a1 = 9'h020; d1 = 8'hA5;
        step();
        idle(3);

        // Contention: both requesters read for 6 cycles.
        v0 = 1; we0 = 0; a0 = 9'h010;
        v1 = 1; we1 = 0; a1 = 9'h020;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin v0 = 0; v1 = 0; end
            @(negedge clk);
            if (i < 6) begin
                chk("cont_gnt0", rdy0_1, (i % 2 == 0));
                chk("cont_gnt1", rdy1_1, (i % 2 == 1));
            end
            if (i > 0) begin
                chk("cont_rsp0", rv0_1, (i % 2 == 1));
                chk("cont_rsp1", rv1_1, (i % 2 == 0));
                if (i % 2 == 1) chk("cont_data0", rd0_1, 8'h5A);
                else            chk("cont_data1", rd1_1, 8'hA5);
            end
            step();
        end
        idle(3);

        // Fairness: req1 transfers alone, then both become valid.
        v1 = 1; we1 = 1; a1 = 9'h030; d1 = 8'h77;
        @(negedge clk);
        chk("fair_solo1", rdy1_1, 1);
        step();
        v0 = 1; we0 = 0; a0 = 9'h010;
        v1 = 1; we1 = 0; a1 = 9'h030;
        @(negedge clk);
        chk("fair_gnt0", rdy0_3, 1);
        chk("fair_gnt1", rdy1_3, 0);
        step();
        v0 = 0;
        step();
        idle(4);

        // A read followed one cycle later by reset never returns.
        v0 = 1; we0 = 0; a0 = 9'h1A5;
        step();
        v0 = 0;
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_flight_l3", rv0_3, 0);
            chk("rst_flight_l1", rv0_1, 0);
            step();
        end

`ifdef RAM_ARB_COUNT_EN
        rst = 1;
        step();
        rst = 0;
        v0 = 1; we0 = 1; a0 = 9'h040; d0 = 8'h01;
        repeat (5) step();
        v0 = 0;
        v1 = 1; we1 = 1; a1 = 9'h041; d1 = 8'h02;
        repeat (3) step();
        v1 = 0;
        @(negedge clk);
        chk("cnt0_five", c0_1, 16'd5);
        chk("cnt1_three", c1_3, 16'd3);
        step();
        force u_lat1.gnt0_cnt = 16'hFFFF;
        force u_lat3.gnt0_cnt = 16'hFFFF;
        m_cnt0 = 16'hFFFF;
        step();
        release u_lat1.gnt0_cnt;
        release u_lat3.gnt0_cnt;
        v0 = 1; we0 = 1; a0 = 9'h042; d0 = 8'h03;
        repeat (2) step();
        v0 = 0;
        @(negedge clk);
        chk("cnt0_sat", c0_1, 16'hFFFF);
        step();
`endif

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arb.md
# ram_arb

Two-requester arbiter that shares one 512x8 `ram` instance between two clients on a single clock domain. Each cycle it grants at most one read or write using round-robin priority and drives the RAM's write and read ports from the winner. It tracks outstanding reads through a latency pipe and returns read data to the requester that issued them. It sits directly in front of `ram`, with `i_wclk` and `i_rclk` of the RAM both tied to this block's `i_clk`.

## Interface
Parameters:
- `AW`, 9: address width; RAM depth is 2^AW.
- `DW`, 8: data width.
- `RD_LAT`, 1: RAM read latency in cycles from `o_ram_re` sampled to `i_ram_rdata` valid. Legal range 1..4.

Ports:
- `i_clk`  in  1  clock; everything is rising-edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req0_valid` / `i_req1_valid`  in  1  request present.
- `i_req0_we` / `i_req1_we`  in  1  1 = write, 0 = read.
- `i_req0_addr` / `i_req1_addr`  in  AW  address.
- `i_req0_wdata` / `i_req1_wdata`  in  DW  write data.
- `o_req0_ready` / `o_req1_ready`  out  1  grant. Transfer occurs when valid & ready.
- `o_rsp0_valid` / `o_rsp1_valid`  out  1  read data valid pulse.
- `o_rsp0_rdata` / `o_rsp1_rdata`  out  DW  read data. Zero when the matching valid is low.
- `o_ram_we`, `o_ram_waddr[AW]`, `o_ram_wdata[DW]`  out  RAM write port.
- `o_ram_re`, `o_ram_raddr[AW]`  out  RAM read port.
- `i_ram_rdata`  in  DW  RAM read data.

## Operation
- **Grant logic** is combinational from the current valids and the priority pointer `prio` (a 1-bit register).
  - Only one valid: that requester is granted.
  - Both valid: requester `prio` is granted.
  - Neither valid: no grant, and all `o_ram_*` are zero.
- **Pointer update:** on any transfer, `prio` is set to the index of the loser (1 − winner). With no transfer, `prio` holds.
- **Exclusivity:** at most one `ready` is high per cycle. `ready` for a non-valid requester is 0.
- **Granted write:** `o_ram_we=1`, `o_ram_waddr/wdata` = winner's addr/wdata, `o_ram_re=0`.
- **Granted read:** `o_ram_re=1`, `o_ram_raddr` = winner's addr, `o_ram_we=0`.
- **Read tracking:** a tag pipe of `RD_LAT` stages carries {valid, id}. The stage entered on a read grant is {1, winner}; every other cycle it is {0, x}. The pipe output drives `o_rspN_valid` for the matching id, and `o_rspN_rdata` = `i_ram_rdata` gated by that valid.
- **No hazard handling:** there is no data forwarding. A read granted the cycle after a write to the same address returns whatever the RAM returns (the new data for `ram`).
- **Ordering:** responses to each requester return in issue order.
- **Reset:**
  - `prio`=0.
  - Tag pipe cleared, so reads in flight at reset never produce `rsp_valid`.
  - All `o_rsp*` outputs are 0.
  - `ready` and `o_ram_*` are forced to 0 while `i_rst`=1.
  - Counters (see Configuration) are cleared.

## Timing
- **Grant:** same cycle as valid (combinational). A requester holds valid/addr/data/we stable until it sees ready.
- **Read response:** a read transferred in cycle N produces `o_rspX_valid=1` for exactly one cycle, in cycle N+`RD_LAT`.
- **Write:** a write transferred in cycle N is committed by the RAM at the end of cycle N and produces no response.
- **Throughput:** one transfer per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1,...
- **First cycle after reset:** with both valid, requester 0 wins.
- **Mixed traffic:** back-to-back reads from different requesters produce back-to-back `rsp_valid` on alternating ports.

## Configuration
- `RAM_ARB_COUNT_EN`: when defined, adds outputs `o_gnt0_cnt` and `o_gnt1_cnt`, each 16 bits.
  - Each counter increments on every transfer of its requester and saturates at 16'hFFFF.
  - Both counters clear on `i_rst`.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- **Reset:** hold `i_rst`=1 with both valid.
  - All ready, rsp and `o_ram_*` outputs are 0.
  - On the first cycle after release, req0 is granted.
- **Single requester write then read:** req0 writes addr 9'h1A5 data 8'hC3, then reads 9'h1A5.
  - `o_rsp0_valid` pulses `RD_LAT` cycles after the read grant, with rdata 8'hC3.
  - `o_rsp1_valid` stays 0.
- **Contention:** both valid for 6 cycles with reads at 9'h010 and 9'h020.
  - Grant order 0,1,0,1,0,1.
  - Responses alternate rsp0/rsp1 with the data preloaded at those addresses.
- **Fairness after idle:** req1 transfers alone, then both become valid.
  - req0 wins first.
- **Reset mid-flight:** issue a read with `RD_LAT`=3, assert `i_rst` one cycle later.
  - No `rsp_valid` ever appears for that read.
- **With `RAM_ARB_COUNT_EN`:** 5 req0 and 3 req1 transfers give `o_gnt0_cnt`=5 and `o_gnt1_cnt`=3. Forcing a counter to 16'hFFFF and granting again leaves it at 16'hFFFF.
